spi_lcd_top: RTL and testbench

Self-contained SPI front end for a Nokia 5110 (PCD8544, 84x48) LCD. After reset it pulses the LCD reset line and sends a fixed command sequence. It then streams glyph data fetched from an external font/text memory: one 6-byte column glyph per address, forever. It sits between the text/font memory and the LCD pins.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/spi_byte_tx.sv | 144 ++++++++++++++
 rtl/spi_lcd_top.sv | 108 ++++++++++
 tb/tb_spi_lcd_top.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and state types for the PCD8544 (Nokia 5110) SPI front end.
// Holds the power-up command sequence, glyph geometry and FSM state enums.
package lcd_pkg;

    localparam int unsigned INIT_LEN    = 8;
    localparam int unsigned GLYPH_BYTES = 6;
    localparam int unsigned LCD_COLS    = 84;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned IDX_W       = 3;

    // Entry 0 is sent first: extended set, Vop, temp coeff, bias, basic set,
    // normal display, X=0, Y=0.
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {
        8'h40, 8'h80, 8'h0C, 8'h20, 8'h14, 8'h04, 8'hB8, 8'h21
    };

    typedef enum logic [2:0] {
        ENG_LCDRST,
        ENG_IDLE,
        ENG_SETUP,
        ENG_SHIFT,
        ENG_DONE
    } eng_state_t;

    typedef enum logic {
        CTL_INIT,
        CTL_DATA
    } ctl_state_t;

endpackage

// File: rtl/spi_byte_tx.sv
// Tick generator plus SPI byte engine driving the LCD pins.
// Ports: clk, rst (async, active high); byte_in/mode/enable accept one byte
// while idle; ready pulses one cycle when the engine becomes idle;
// SCK/MOSI/DC/CS/LCD_reset go straight to the panel.
module spi_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV_LOG2  = 3,
    parameter int unsigned LCD_RST_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       mode,
    input  logic       enable,
    output logic       ready,
    output logic       SCK,
    output logic       MOSI,
    output logic       DC,
    output logic       CS,
    output logic       LCD_reset
);

    localparam int unsigned RST_W = $clog2(LCD_RST_TICKS + 1);

    logic [CLK_DIV_LOG2-1:0] div_cnt;
    logic                    tick_c;

    eng_state_t       state, state_d;
    logic [RST_W-1:0] rst_cnt, rst_cnt_d;
    logic [3:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       sh, sh_d;
    logic             mode_q, mode_d;
    logic             ready_d, sck_d, mosi_d, dc_d, cs_d, lcd_reset_d;

    // Free-running divider; tick is a clock enable on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= div_cnt + CLK_DIV_LOG2'(1);
    end

    assign tick_c = &div_cnt;

    // State and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENG_LCDRST;
            rst_cnt   <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            mode_q    <= 1'b0;
            ready     <= 1'b0;
            SCK       <= 1'b0;
            MOSI      <= 1'b0;
            DC        <= 1'b0;
            CS        <= 1'b1;
            LCD_reset <= 1'b0;
        end else begin
            state     <= state_d;
            rst_cnt   <= rst_cnt_d;
            bit_cnt   <= bit_cnt_d;
            sh        <= sh_d;
            mode_q    <= mode_d;
            ready     <= ready_d;
            SCK       <= sck_d;
            MOSI      <= mosi_d;
            DC        <= dc_d;
            CS        <= cs_d;
            LCD_reset <= lcd_reset_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        rst_cnt_d   = rst_cnt;
        bit_cnt_d   = bit_cnt;
        sh_d        = sh;
        mode_d      = mode_q;
        ready_d     = 1'b0;
        sck_d       = SCK;
        mosi_d      = MOSI;
        dc_d        = DC;
        cs_d        = CS;
        lcd_reset_d = LCD_reset;

        case (state)
            ENG_LCDRST: begin
                if (tick_c) begin
                    if (rst_cnt == RST_W'(LCD_RST_TICKS - 1)) begin
                        lcd_reset_d = 1'b1;
                        ready_d     = 1'b1;
                        state_d     = ENG_IDLE;
                    end else begin
                        rst_cnt_d = rst_cnt + RST_W'(1);
                    end
                end
            end
            ENG_IDLE: begin
                cs_d  = 1'b1;
                sck_d = 1'b0;
                // Latch on any cycle; the byte starts on the next tick.
                if (enable) begin
                    sh_d    = byte_in;
                    mode_d  = mode;
                    state_d = ENG_SETUP;
                end
            end
            ENG_SETUP: begin
                if (tick_c) begin
                    cs_d      = 1'b0;
                    dc_d      = mode_q;
                    mosi_d    = sh[7];
                    bit_cnt_d = '0;
                    state_d   = ENG_SHIFT;
                end
            end
            ENG_SHIFT: begin
                if (tick_c) begin
                    bit_cnt_d = bit_cnt + 4'd1;
                    if (!SCK) begin
                        sck_d = 1'b1;
                    end else begin
                        // Data moves on the falling edge so the panel samples on rising.
                        sck_d  = 1'b0;
                        mosi_d = sh[6];
                        sh_d   = {sh[6:0], 1'b0};
                    end
                    if (bit_cnt == 4'd15) state_d = ENG_DONE;
                end
            end
            ENG_DONE: begin
                if (tick_c) begin
                    cs_d    = 1'b1;
                    sck_d   = 1'b0;
                    ready_d = 1'b1;
                    state_d = ENG_IDLE;
                end
            end
            default: state_d = ENG_LCDRST;
        endcase
    end

endmodule

// File: rtl/spi_lcd_top.sv
// PCD8544 front end: sends the init command list once, then streams 6-byte
// column glyphs from an external memory indexed by mem_address (0..83).
// Ports: clk, rst (async, active high); data_in glyph (byte 0 first);
// mem_address glyph index; ready byte-engine idle pulse; LCD pins.
module spi_lcd_top
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV_LOG2  = 3,
    parameter int unsigned LCD_RST_TICKS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           data_in,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  ready,
    output logic                  SCK,
    output logic                  MOSI,
    output logic                  DC,
    output logic                  CS,
    output logic                  LCD_reset
);

    ctl_state_t                  phase, phase_d;
    logic [IDX_W-1:0]            idx, idx_d;
    logic [ADDR_W-1:0]           addr_d;
    logic                        en_q, en_d;
    logic [7:0]                  byte_q, byte_d;
    logic                        mode_q, mode_d;
    logic [GLYPH_BYTES-1:0][7:0] glyph_c;

    assign glyph_c = data_in;

    spi_byte_tx #(
        .CLK_DIV_LOG2  (CLK_DIV_LOG2),
        .LCD_RST_TICKS (LCD_RST_TICKS)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_q),
        .mode      (mode_q),
        .enable    (en_q),
        .ready     (ready),
        .SCK       (SCK),
        .MOSI      (MOSI),
        .DC        (DC),
        .CS        (CS),
        .LCD_reset (LCD_reset)
    );

    // Controller state, handshake and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= CTL_INIT;
            idx         <= '0;
            mem_address <= '0;
            en_q        <= 1'b0;
            byte_q      <= '0;
            mode_q      <= 1'b0;
        end else begin
            phase       <= phase_d;
            idx         <= idx_d;
            mem_address <= addr_d;
            en_q        <= en_d;
            byte_q      <= byte_d;
            mode_q      <= mode_d;
        end
    end

    // Each ready pulse issues the next byte; the address advances as the
    // last byte of a glyph is handed over, giving memory a full byte time.
    always_comb begin
        phase_d = phase;
        idx_d   = idx;
        addr_d  = mem_address;
        en_d    = 1'b0;
        byte_d  = byte_q;
        mode_d  = mode_q;

        if (ready) begin
            en_d = 1'b1;
            case (phase)
                CTL_INIT: begin
                    byte_d = INIT_CMDS[idx];
                    mode_d = 1'b0;
                    if (idx == IDX_W'(INIT_LEN - 1)) begin
                        idx_d   = '0;
                        phase_d = CTL_DATA;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
                CTL_DATA: begin
                    byte_d = glyph_c[idx];
                    mode_d = 1'b1;
                    if (idx == IDX_W'(GLYPH_BYTES - 1)) begin
                        idx_d  = '0;
                        addr_d = (mem_address == ADDR_W'(LCD_COLS - 1))
                                 ? '0 : mem_address + ADDR_W'(1);
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
                default: phase_d = CTL_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_lcd_top.sv
// Scoreboard bench for spi_lcd_top: expected bytes are queued when stimulus
// is issued; a monitor decodes SPI frames from the pins and compares.
module tb_spi_lcd_top;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] data_in;
    logic [6:0]  mem_address;
    logic        ready, SCK, MOSI, DC, CS, LCD_reset;

    always #5 clk = ~clk;

    spi_lcd_top dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .mem_address (mem_address),
        .ready       (ready),
        .SCK         (SCK),
        .MOSI        (MOSI),
        .DC          (DC),
        .CS          (CS),
        .LCD_reset   (LCD_reset)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       dc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] init_seq [8];
    int         n_ready;
    time        last_ready_t;
    bit         aborted = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_glyph(input logic [47:0] g);
        for (int k = 0; k < 6; k++) exp_q.push_back({g[8*k +: 8], 1'b1});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sck"}, SCK, 0);
        chk({tag, "_mosi"}, MOSI, 0);
        chk({tag, "_dc"}, DC, 0);
        chk({tag, "_cs"}, CS, 1);
        chk({tag, "_lcd_reset"}, LCD_reset, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_ready"}, ready, 0);
    endtask

    // ---------------- monitor: decode SPI frames ----------------
    logic       prev_cs = 1'b1, prev_sck = 1'b0;
    int         nbits = 0, cyc = 0, last_rise = 0, cs_rise_cyc = 0;
    bit         in_byte = 0;
    logic [7:0] shv;
    logic       dcs;
    exp_t       e;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            nbits = 0;
            in_byte = 0;
            cs_rise_cyc = 0;
        end else begin
            if (prev_cs && !CS) begin
                nbits = 0;
                in_byte = 1;
                dcs = DC;
                if (cs_rise_cyc > 0) chk("cs_high_gap_ge8", 64'((cyc - cs_rise_cyc) >= 8), 1);
            end
            if (!CS && !prev_sck && SCK) begin
                if (nbits > 0) chk("sck_period", 64'(cyc - last_rise), 16);
                last_rise = cyc;
                shv = {shv[6:0], MOSI};
                nbits++;
            end
            if (!prev_cs && CS && in_byte) begin
                chk("rising_edges_per_byte", 64'(nbits), 8);
                cs_rise_cyc = cyc;
                in_byte = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h dc %0b, expected none", shv, dcs);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_value", shv, e.b);
                    chk("byte_dc", dcs, e.dc);
                end
            end
        end
        prev_cs = CS;
        prev_sck = SCK;
    end

    // ---------------- stimulus ----------------
    task automatic start_seq(input string tag);
        int cnt;
        rst = 1'b1;
        exp_q.delete();
        data_in = 48'h0605_0403_0201;
        for (int i = 0; i < 8; i++) exp_q.push_back({init_seq[i], 1'b0});
        push_glyph(data_in);
        repeat (3) @(negedge clk);
        check_reset_outputs({tag, "_held"});
        rst = 1'b0;
        cnt = 0;
        while (!LCD_reset && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_lcd_reset_cycles"}, 64'(cnt), 128);
        chk({tag, "_first_ready"}, ready, 1);
        n_ready = 1;
        last_ready_t = $time;
    endtask

    task automatic run_readies(input int upto);
        int w, k, g;
        while (n_ready < upto && !aborted) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!ready && w < 300);
            if (!ready) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: no ready after %0d cycles, expected one within 144", w);
                aborted = 1;
            end else begin
                n_ready++;
                chk("ready_interval", 64'(($time - last_ready_t) / 10), 144);
                last_ready_t = $time;
                if (n_ready >= 9) begin
                    k = (n_ready - 9) % 6;
                    g = (n_ready - 9) / 6;
                    if (k == 0) chk("addr_glyph_start", mem_address, 64'(g % 84));
                    if (k == 5) begin
                        chk("addr_before_inc", mem_address, 64'(g % 84));
                        @(negedge clk);
                        chk("addr_after_inc", mem_address, 64'((g + 1) % 84));
                        repeat (4) @(negedge clk);
                        data_in = {16'($urandom), 32'($urandom)};
                        push_glyph(data_in);
                    end
                end
            end
        end
    endtask

    initial begin
        int w;
        init_seq = '{8'h21, 8'hB8, 8'h04, 8'h14, 8'h20, 8'h0C, 8'h80, 8'h40};
        data_in = '0;

        // Phase 1: init plus part of the first glyph, then reset mid-byte.
        start_seq("rst1");
        run_readies(11);
        w = 0;
        while (CS && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("cs_low_before_abort", CS, 0);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midbyte");
        @(negedge clk);

        // Phase 2: full restart, 84 glyphs and the address wrap.
        if (!aborted) begin
            start_seq("rst2");
            run_readies(9 + 84 * 6 + 1);
            repeat (200) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
